// File: rtl/dcim_pkg.sv
// Shared types and helpers for the DCIM bit-serial shift-and-add accumulator.
package dcim_pkg;

  // Controller states: waiting for a job, or consuming bit planes
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Signed result width that cannot overflow for any unsigned or two's-complement job
  function automatic int acc_width(input int psumW, input int inBits);
    return psumW + inBits + 1;
  endfunction

  // Low bit index of lane idx inside a packed bus of width-bit lanes
  function automatic int sliceLo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/dcim_shift_acc_lane.sv
// One accumulator column: first-plane load (optionally negated) or shift-and-add.
module dcim_shift_acc_lane
  import dcim_pkg::*;
#(
  parameter int PSUM_W = 6,
  parameter int ACC_W  = 15
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    init_i,
  input  logic                    beat_i,
  input  logic                    first_i,
  input  logic                    negate_i,
  input  logic [PSUM_W-1:0]       psum_i,
  output logic signed [ACC_W-1:0] sum_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] pExt;

  assign pExt = signed'({{(ACC_W-PSUM_W){1'b0}}, psum_i});

  // Value this lane takes if the current cycle is a beat; MSB plane carries negative weight in signed mode
  always_comb begin
    sum_o = (acc_q <<< 1) + pExt;
    if (first_i) begin
      sum_o = negate_i ? -pExt : pExt;
    end
  end

  // Clear on job start, update on beat, otherwise hold across gaps
  always_comb begin
    acc_d = acc_q;
    if (init_i) begin
      acc_d = '0;
    end else if (beat_i) begin
      acc_d = sum_o;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dcim_shift_accumulator.sv
// Multi-column bit-serial accumulator: FSM, plane counter, mode latch, handshakes and result register.
module dcim_shift_accumulator
  import dcim_pkg::*;
#(
  parameter int  NUM_COL = 8,
  parameter int  PSUM_W  = 6,
  parameter int  IN_BITS = 8,
  localparam int ACC_W   = acc_width(PSUM_W, IN_BITS)
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic                       clear,
  input  logic                       psum_valid,
  output logic                       psum_ready,
  input  logic [NUM_COL*PSUM_W-1:0]  psum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_COL*ACC_W-1:0]   acc_out,
  output logic                       busy
);

  localparam int CNT_W = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
  localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(IN_BITS - 1);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           bitCnt_q, bitCnt_d;
  logic                       signedMode_q, signedMode_d;
  logic [NUM_COL*ACC_W-1:0]   accOut_q, accOut_d;
  logic                       outValid_q, outValid_d;
  logic [NUM_COL*ACC_W-1:0]   laneSum;
  logic                       jobStart;
  logic                       beat;
  logic                       lastPlane;
  logic                       firstPlane;
  logic                       lastBeat;

  assign lastPlane  = (bitCnt_q == '0);
  assign firstPlane = (bitCnt_q == FIRST_CNT);
  assign jobStart   = (state_q == IDLE) && start;
  assign psum_ready = (state_q == ACCUM) && !clear && !(lastPlane && outValid_q && !out_ready);
  assign beat       = psum_valid && psum_ready;
  assign lastBeat   = beat && lastPlane;
  assign busy       = (state_q == ACCUM);
  assign out_valid  = outValid_q;
  assign acc_out    = accOut_q;

  // Next-state logic: start opens a job, last accepted plane or clear returns to idle
  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    signedMode_d = signedMode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = ACCUM;
          bitCnt_d     = FIRST_CNT;
          signedMode_d = signed_mode;
        end
      end
      ACCUM: begin
        if (clear) begin
          state_d = IDLE;
        end else if (beat) begin
          if (lastPlane) begin
            state_d = IDLE;
          end else begin
            bitCnt_d = bitCnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, plane counter and mode latch registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      signedMode_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitCnt_q     <= bitCnt_d;
      signedMode_q <= signedMode_d;
    end
  end

  // One accumulator lane per column
  for (genvar c = 0; c < NUM_COL; c++) begin : gLane
    dcim_shift_acc_lane #(
      .PSUM_W (PSUM_W),
      .ACC_W  (ACC_W)
    ) uLane (
      .clk      (clk),
      .rst_b    (rst_b),
      .init_i   (jobStart),
      .beat_i   (beat),
      .first_i  (firstPlane),
      .negate_i (signedMode_q),
      .psum_i   (psum[sliceLo(c, PSUM_W) +: PSUM_W]),
      .sum_o    (laneSum[sliceLo(c, ACC_W) +: ACC_W])
    );
  end

  // Result register: loads on last beat, otherwise drains on handshake
  always_comb begin
    accOut_d   = accOut_q;
    outValid_d = outValid_q;
    if (lastBeat) begin
      accOut_d   = laneSum;
      outValid_d = 1'b1;
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // Result and valid registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      accOut_q   <= '0;
      outValid_q <= 1'b0;
    end else begin
      accOut_q   <= accOut_d;
      outValid_q <= outValid_d;
    end
  end

endmodule

// File: tb/tb_dcim_shift_accumulator.sv
// Directed table-driven bench for dcim_shift_accumulator (2 columns, 4-bit psums, 4 planes).
module tb_dcim_shift_accumulator;

  localparam int NUM_COL = 2;
  localparam int PSUM_W  = 4;
  localparam int IN_BITS = 4;
  localparam int ACC_W   = 9;

  logic clk;
  logic rst_b;
  logic start;
  logic signed_mode;
  logic clear;
  logic psum_valid;
  logic psum_ready;
  logic [NUM_COL*PSUM_W-1:0] psum;
  logic out_valid;
  logic out_ready;
  logic [NUM_COL*ACC_W-1:0] acc_out;
  logic busy;

  int testsRun;
  int testsFailed;

  // Planes packed MSB-plane first: plane k is nibble [15-4k -: 4]
  typedef struct {
    logic              signedMode;
    logic [15:0]       planes0;
    logic [15:0]       planes1;
    logic signed [8:0] exp0;
    logic signed [8:0] exp1;
  } vec_t;

  vec_t vecs[6];

  dcim_shift_accumulator #(
    .NUM_COL (NUM_COL),
    .PSUM_W  (PSUM_W),
    .IN_BITS (IN_BITS)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .start       (start),
    .signed_mode (signed_mode),
    .clear       (clear),
    .psum_valid  (psum_valid),
    .psum_ready  (psum_ready),
    .psum        (psum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .acc_out     (acc_out),
    .busy        (busy)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkResult(input string name, input logic signed [8:0] e0, input logic signed [8:0] e1);
    checkOutput({name, "_col0"}, {23'b0, acc_out[8:0]}, {23'b0, e0});
    checkOutput({name, "_col1"}, {23'b0, acc_out[17:9]}, {23'b0, e1});
  endtask

  function automatic logic [7:0] planeBus(input vec_t v, input int k);
    return {v.planes1[15-4*k -: 4], v.planes0[15-4*k -: 4]};
  endfunction

  // Runs one job from a negedge; optional gap before plane gapAt; ends at the negedge after the last beat
  task automatic applyStimulus(input vec_t v, input int gapAt, input int gapLen);
    int waitCnt;
    start       = 1'b1;
    signed_mode = v.signedMode;
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("startLatency", {31'b0, psum_ready}, 32'd1);
    for (int k = 0; k < IN_BITS; k++) begin
      if (k == gapAt) begin
        for (int g = 0; g < gapLen; g++) begin
          psum_valid = 1'b0;
          @(negedge clk);
          checkOutput("gapBitCnt", 32'(dut.bitCnt_q), 32'(IN_BITS - 1 - k));
        end
      end
      psum_valid = 1'b1;
      psum       = planeBus(v, k);
      waitCnt    = 0;
      #1;
      while (!psum_ready && waitCnt < 20) begin
        @(negedge clk);
        #1;
        waitCnt++;
      end
      if (!psum_ready) begin
        checkOutput("readyTimeout", 32'd0, 32'd1);
      end
      @(negedge clk);
    end
    psum_valid = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_b       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    clear       = 1'b0;
    psum_valid  = 1'b0;
    psum        = '0;
    out_ready   = 1'b1;

    vecs[0] = '{1'b0, 16'h1011, 16'hFFFF,  9'sd11,   9'sd225};
    vecs[1] = '{1'b1, 16'h3001, 16'hF000, -9'sd23,  -9'sd120};
    vecs[2] = '{1'b1, 16'h0FFF, 16'hFFFF,  9'sd105, -9'sd15};
    vecs[3] = '{1'b0, 16'h0000, 16'h8421,  9'sd0,    9'sd85};
    vecs[4] = '{1'b1, 16'h5271, 16'h1111, -9'sd17,  -9'sd1};
    vecs[5] = '{1'b0, 16'h5271, 16'h9306,  9'sd63,   9'sd90};

    // Reset state
    #3;
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
    checkOutput("rstPsumReady", {31'b0, psum_ready}, 32'd0);
    checkOutput("rstAccOut", {14'b0, acc_out}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    // Table of jobs, back to back
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], -1, 0);
      checkOutput("jobOutValid", {31'b0, out_valid}, 32'd1);
      checkOutput("jobBusyIdle", {31'b0, busy}, 32'd0);
      checkResult("job", vecs[i].exp0, vecs[i].exp1);
      @(negedge clk);
      checkOutput("jobDrained", {31'b0, out_valid}, 32'd0);
    end

    // Gaps of 3 cycles between planes 2 and 3
    applyStimulus(vecs[0], 2, 3);
    checkOutput("gapOutValid", {31'b0, out_valid}, 32'd1);
    checkResult("gap", 9'sd11, 9'sd225);
    @(negedge clk);

    // Backpressure: hold job A, run job B up to its last plane
    out_ready = 1'b0;
    applyStimulus(vecs[0], -1, 0);
    checkResult("bpA", 9'sd11, 9'sd225);
    start       = 1'b1;
    signed_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < IN_BITS; k++) begin
      psum_valid = 1'b1;
      psum       = planeBus(vecs[1], k);
      #1;
      checkOutput("bpReady", {31'b0, psum_ready}, (k < IN_BITS - 1) ? 32'd1 : 32'd0);
      if (k < IN_BITS - 1) begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    #1;
    checkOutput("bpStall", {31'b0, psum_ready}, 32'd0);
    checkOutput("bpHoldValid", {31'b0, out_valid}, 32'd1);
    checkResult("bpHold", 9'sd11, 9'sd225);
    out_ready = 1'b1;
    #1;
    checkOutput("bpRelease", {31'b0, psum_ready}, 32'd1);
    @(negedge clk);
    psum_valid = 1'b0;
    checkOutput("bpBValid", {31'b0, out_valid}, 32'd1);
    checkResult("bpB", -9'sd23, -9'sd120);
    @(negedge clk);
    checkOutput("bpBDrained", {31'b0, out_valid}, 32'd0);

    // Abort after two beats; clear drops the same-cycle beat
    start       = 1'b1;
    signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      psum_valid = 1'b1;
      psum       = planeBus(vecs[3], k);
      @(negedge clk);
    end
    clear = 1'b1;
    #1;
    checkOutput("abortReady", {31'b0, psum_ready}, 32'd0);
    @(negedge clk);
    clear      = 1'b0;
    psum_valid = 1'b0;
    checkOutput("abortBusy", {31'b0, busy}, 32'd0);
    checkOutput("abortOutValid", {31'b0, out_valid}, 32'd0);
    checkResult("abortHold", -9'sd23, -9'sd120);
    applyStimulus(vecs[5], -1, 0);
    checkResult("afterAbort", 9'sd63, 9'sd90);
    @(negedge clk);

    // start and signed_mode pulsed mid-job are ignored
    start       = 1'b1;
    signed_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < IN_BITS; k++) begin
      psum_valid  = 1'b1;
      psum        = planeBus(vecs[2], k);
      start       = (k == 1);
      signed_mode = (k != 1);
      @(negedge clk);
      if (k == 1) begin
        checkOutput("ignStartCnt", 32'(dut.bitCnt_q), 32'd1);
        checkOutput("ignStartBusy", {31'b0, busy}, 32'd1);
      end
    end
    start      = 1'b0;
    psum_valid = 1'b0;
    checkResult("ignStart", 9'sd105, -9'sd15);
    @(negedge clk);

    // Asynchronous reset in the middle of a job with a held result
    out_ready = 1'b0;
    applyStimulus(vecs[0], -1, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      psum_valid = 1'b1;
      psum       = planeBus(vecs[1], k);
      @(negedge clk);
    end
    #2;
    rst_b = 1'b0;
    #1;
    checkOutput("amidBusy", {31'b0, busy}, 32'd0);
    checkOutput("amidOutValid", {31'b0, out_valid}, 32'd0);
    checkOutput("amidPsumReady", {31'b0, psum_ready}, 32'd0);
    checkOutput("amidAccOut", {14'b0, acc_out}, 32'd0);
    psum_valid = 1'b0;
    out_ready  = 1'b1;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
